// File: rtl/crash_handler.sv
// Turns the collision detector's overlap flag into crash behaviour for the player car:
// a two-frame debounce, lives count, freeze period, blinking invulnerability and a latched game over.
//
// state  | meaning
// ALIVE  | normal play, collisions are debounced and counted
// CRASH  | car frozen for CRASH_FRAMES frames, collisions ignored
// INVULN | car blinks for INVULN_FRAMES frames, collisions ignored
// OVER   | no lives left, frozen until restart
module crash_handler #(
  parameter int LIVES         = 3,
  parameter int CRASH_FRAMES  = 30,
  parameter int INVULN_FRAMES = 90,
  parameter int BLINK_BIT     = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       ifcollision,
  input  logic       restart,
  output logic [1:0] state,
  output logic [2:0] lives,
  output logic       crash_pulse,
  output logic       freeze,
  output logic       visible,
  output logic       game_over
);

  typedef enum logic [1:0] {
    ALIVE  = 2'd0,
    CRASH  = 2'd1,
    INVULN = 2'd2,
    OVER   = 2'd3
  } state_t;

  localparam logic [2:0] LIVES_INIT  = 3'(LIVES);
  localparam logic [7:0] CRASH_LOAD  = 8'(CRASH_FRAMES - 1);
  localparam logic [7:0] INVULN_LOAD = 8'(INVULN_FRAMES - 1);

  state_t     st;
  logic [7:0] cnt;
  logic       hist;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st          <= ALIVE;
      lives       <= LIVES_INIT;
      cnt         <= 8'd0;
      hist        <= 1'b0;
      crash_pulse <= 1'b0;
    end else begin
      crash_pulse <= 1'b0;
      if (restart) begin
        st    <= ALIVE;
        lives <= LIVES_INIT;
        cnt   <= 8'd0;
        hist  <= 1'b0;
      end else if (frame_tick) begin
        case (st)
          ALIVE: begin
            if (ifcollision && hist && (lives != 3'd0)) begin
              crash_pulse <= 1'b1;
              lives       <= lives - 3'd1;
              // clearing hist means a held overlap must re-confirm over two fresh ticks
              hist        <= 1'b0;
              if (lives == 3'd1) begin
                st <= OVER;
              end else begin
                st  <= CRASH;
                cnt <= CRASH_LOAD;
              end
            end else begin
              hist <= ifcollision;
            end
          end
          CRASH: begin
            hist <= 1'b0;
            if (cnt == 8'd0) begin
              st  <= INVULN;
              cnt <= INVULN_LOAD;
            end else begin
              cnt <= cnt - 8'd1;
            end
          end
          INVULN: begin
            hist <= 1'b0;
            if (cnt == 8'd0) begin
              st <= ALIVE;
            end else begin
              cnt <= cnt - 8'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign state     = st;
  assign freeze    = (st == CRASH) || (st == OVER);
  assign game_over = (st == OVER);
  assign visible   = (st != INVULN) || !cnt[BLINK_BIT];

endmodule

// File: tb/tb_crash_handler.sv
// Scoreboard bench for crash_handler: stimulus queues expected snapshots, a negedge monitor
// pops and compares them and independently counts crash pulses.
module tb_crash_handler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic       ifcollision = 1'b0;
  logic       restart = 1'b0;
  logic [1:0] state;
  logic [2:0] lives;
  logic       crash_pulse;
  logic       freeze;
  logic       visible;
  logic       game_over;

  crash_handler #(
    .LIVES(3), .CRASH_FRAMES(30), .INVULN_FRAMES(90), .BLINK_BIT(3)
  ) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .ifcollision(ifcollision),
    .restart(restart), .state(state), .lives(lives), .crash_pulse(crash_pulse),
    .freeze(freeze), .visible(visible), .game_over(game_over)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [1:0] st;
    logic [2:0] lv;
    logic       fz;
    logic       vis;
    logic       go;
    int         pulses;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   pulses = 0;
  int   ep = 0;

  always @(negedge clk) begin
    if (crash_pulse === 1'b1) pulses++;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (state !== e.st || lives !== e.lv || freeze !== e.fz || visible !== e.vis ||
          game_over !== e.go || pulses != e.pulses) begin
        errors++;
        $display("FAIL %s: got st=%0d lives=%0d freeze=%b vis=%b go=%b pulses=%0d, expected st=%0d lives=%0d freeze=%b vis=%b go=%b pulses=%0d",
                 e.name, state, lives, freeze, visible, game_over, pulses,
                 e.st, e.lv, e.fz, e.vis, e.go, e.pulses);
      end
    end
  end

  task automatic expect_now(input string n, input logic [1:0] s, input logic [2:0] l,
                            input logic vis, input int p);
    exp_t x;
    x.name   = n;
    x.st     = s;
    x.lv     = l;
    x.fz     = (s == 2'd1) || (s == 2'd3);
    x.go     = (s == 2'd3);
    x.vis    = vis;
    x.pulses = p;
    q.push_back(x);
  endtask

  task automatic do_tick(input logic col, input logic rs = 1'b0);
    @(posedge clk); #1;
    frame_tick  = 1'b1;
    ifcollision = col;
    restart     = rs;
    @(posedge clk); #1;
    frame_tick = 1'b0;
    restart    = 1'b0;
  endtask

  initial begin
    logic [7:0] cv;
    @(posedge clk); #1;
    expect_now("reset_values", 2'd0, 3'd3, 1'b1, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // single-tick overlap and an overlap only between ticks never count
    do_tick(1'b1);
    do_tick(1'b0);
    expect_now("single_tick_no_hit", 2'd0, 3'd3, 1'b1, 0);
    @(posedge clk); #1; ifcollision = 1'b1;
    @(posedge clk); #1; ifcollision = 1'b0;
    do_tick(1'b1);
    do_tick(1'b0);
    expect_now("between_tick_glitch", 2'd0, 3'd3, 1'b1, 0);

    // confirmed hit and full freeze window
    do_tick(1'b1);
    expect_now("first_tick_pending", 2'd0, 3'd3, 1'b1, 0);
    do_tick(1'b1);
    ep = 1;
    expect_now("hit1_crash", 2'd1, 3'd2, 1'b1, ep);
    for (int i = 1; i <= 29; i++) begin
      do_tick(1'b1);
      expect_now("crash_hold", 2'd1, 3'd2, 1'b1, ep);
    end
    do_tick(1'b1);
    expect_now("invuln_entry", 2'd2, 3'd2, 1'b0, ep);
    for (int j = 1; j <= 89; j++) begin
      do_tick(1'b1);
      cv = 8'(89 - j);
      expect_now("invuln_blink", 2'd2, 3'd2, ~cv[3], ep);
    end
    do_tick(1'b1);
    expect_now("back_alive", 2'd0, 3'd2, 1'b1, ep);
    do_tick(1'b1);
    expect_now("rehit_pending", 2'd0, 3'd2, 1'b1, ep);
    do_tick(1'b1);
    ep = 2;
    expect_now("hit2_crash", 2'd1, 3'd1, 1'b1, ep);

    // run out the second crash, then the last life
    for (int i = 0; i < 30; i++) do_tick(1'b0);
    expect_now("hit2_invuln", 2'd2, 3'd1, 1'b0, ep);
    for (int i = 0; i < 90; i++) do_tick(1'b0);
    expect_now("hit2_alive", 2'd0, 3'd1, 1'b1, ep);
    do_tick(1'b1);
    do_tick(1'b1);
    ep = 3;
    expect_now("hit3_over", 2'd3, 3'd0, 1'b1, ep);
    for (int i = 1; i <= 500; i++) begin
      do_tick(i[0]);
      if (i % 100 == 0) expect_now("over_hold", 2'd3, 3'd0, 1'b1, ep);
    end

    @(posedge clk); #1; restart = 1'b1;
    @(posedge clk); #1; restart = 1'b0;
    expect_now("restart_from_over", 2'd0, 3'd3, 1'b1, ep);

    // restart beats a confirming tick in the same clk and clears history
    do_tick(1'b1);
    do_tick(1'b1, 1'b1);
    expect_now("restart_wins", 2'd0, 3'd3, 1'b1, ep);
    do_tick(1'b1);
    expect_now("restart_cleared_hist", 2'd0, 3'd3, 1'b1, ep);
    do_tick(1'b1);
    ep = 4;
    expect_now("hit_after_restart", 2'd1, 3'd2, 1'b1, ep);

    // asynchronous reset in the middle of a crash (cnt=12)
    for (int i = 0; i < 17; i++) do_tick(1'b0);
    expect_now("crash_cnt12", 2'd1, 3'd2, 1'b1, ep);
    @(posedge clk); #1;
    rst = 1'b1;
    expect_now("async_reset_mid_crash", 2'd0, 3'd3, 1'b1, ep);
    @(posedge clk); #1;
    rst = 1'b0;
    do_tick(1'b1);
    do_tick(1'b1);
    ep = 5;
    expect_now("hit_after_reset", 2'd1, 3'd2, 1'b1, ep);

    for (int k = 0; k < 20 && q.size() > 0; k++) @(posedge clk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d expectations left, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/crash_handler.md
Name: crash_handler

Overview:
- Consumes the `ifcollision` flag from the collision detector and turns it into game-level crash behaviour for the player car.
- Debounces the raw flag, counts down lives, freezes the car during a crash, then gives a blinking invulnerability window.
- Latches game over until restart.
- Sits between the collision detector and the player-movement and sprite-render stages; all timing is in VGA frames.

Parameters:
- LIVES, 3: lives at reset and restart; range 1..7.
- CRASH_FRAMES, 30: frames the car stays frozen after a confirmed hit; range 1..256.
- INVULN_FRAMES, 90: frames of blinking invulnerability after the freeze; range 1..256.
- BLINK_BIT, 3: counter bit that drives blinking; visibility toggles every 2^BLINK_BIT frames.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- frame_tick  in  1  one-clk pulse per VGA frame; all sampling and counting happen on it.
- ifcollision  in  1  combinational overlap flag from the collision detector.
- restart  in  1  synchronous request for a new game; level-sensitive, acted on every clk.
- state  out  2  0 ALIVE, 1 CRASH, 2 INVULN, 3 OVER.
- lives  out  3  remaining lives.
- crash_pulse  out  1  one-clk pulse on each confirmed hit.
- freeze  out  1  high means player-movement ignores steering and throttle.
- visible  out  1  sprite enable for the renderer.
- game_over  out  1  high in OVER.

Behaviour:
- Reset is asynchronous, active-high. While asserted:
  - state=ALIVE, lives=LIVES, frame counter cnt(8b)=0, history bit hist=0.
  - crash_pulse=0, freeze=0, visible=1, game_over=0.
- Registers that update only on frame_tick: hist, cnt and the state transitions other than restart. restart and the crash_pulse return-to-0 act on any clk.
- Decoded outputs, from registered state and cnt only:
  - freeze = (state==CRASH) | (state==OVER).
  - game_over = (state==OVER).
  - visible = 1 except in INVULN, where visible = ~cnt[BLINK_BIT].
- Debounce (ALIVE only):
  - On each frame_tick, hist <= ifcollision.
  - Confirmed hit = frame_tick & ifcollision & hist, i.e. high on two consecutive frame_ticks.
  - ifcollision between ticks is ignored, so glitches from position updates never count.
- ALIVE, on a confirmed hit:
  - lives <= lives-1 and crash_pulse <= 1 for exactly the next clk.
  - If lives==1 before the decrement: state <= OVER (lives becomes 0).
  - Otherwise: state <= CRASH, cnt <= CRASH_FRAMES-1.
  - hist <= 0, so a sustained overlap cannot double-count.
- CRASH:
  - Collisions ignored; hist held at 0.
  - Each frame_tick: if cnt==0, state <= INVULN and cnt <= INVULN_FRAMES-1; else cnt <= cnt-1.
  - Freeze therefore lasts exactly CRASH_FRAMES frame_ticks.
- INVULN:
  - Collisions ignored; hist held at 0.
  - Each frame_tick: if cnt==0, state <= ALIVE; else cnt <= cnt-1.
  - Overlap still present on returning to ALIVE needs two further ticks to confirm.
- OVER: holds indefinitely; ifcollision and frame_tick are ignored.
- restart:
  - Priority over every frame_tick action in the same clk, in any state.
  - Effect: state <= ALIVE, lives <= LIVES, cnt <= 0, hist <= 0, crash_pulse <= 0.
- Reset mid-crash or mid-invulnerability returns immediately to the reset values; no pulse is generated.
- lives never wraps below 0. No decrement occurs outside ALIVE.
- Widths: cnt is 8b unsigned and loads PARAM-1, so a value of 256 loads 255.

Test Plan:
- After reset, ifcollision=1 for 1 tick then 0 -> no crash_pulse; state stays ALIVE; lives=3.
- ifcollision=1 held over 2 ticks -> crash_pulse once, 1 clk after the second tick; lives=2; state=CRASH; freeze=1 for exactly 30 ticks; then INVULN.
- In INVULN with BLINK_BIT=3 -> visible toggles every 8 ticks; ifcollision=1 throughout gives no pulse; state=ALIVE after 90 ticks; held overlap re-hits 2 ticks later, lives=1.
- Three confirmed hits -> lives=0, state=OVER, game_over=1, freeze=1 held through 500 further ticks; restart pulse -> ALIVE, lives=3, visible=1.
- restart and a confirmed-hit tick in the same clk -> restart wins: lives=3, no crash_pulse.
- rst asserted mid-CRASH (cnt=12) -> outputs return to reset values asynchronously, before the next clk edge; state=ALIVE, freeze=0.
